// File: rtl/instruction_fetch_unit_if.sv
// Bundle between the fetch unit, the control unit and the instruction ROM.
//   master : control/ROM side. It drives requests, redirects and rom_data,
//            and observes the fetch state.
//   slave  : fetch unit. It drives rom_addr/rom_rw and its fetch state, and
//            observes requests, redirects and rom_data.
interface instruction_fetch_unit_if;
  logic        fetch_req;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic [31:0] branch_offset;
  logic [25:0] jump_index;
  logic [31:0] jr_target;
  logic [31:0] rom_addr;
  logic        rom_rw;
  logic [31:0] rom_data;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  modport master (
    output fetch_req, pc_write, pc_src, branch_offset, jump_index, jr_target, rom_data,
    input  rom_addr, rom_rw, pc, instr, instr_valid, fetch_fault, fetch_count
  );

  modport slave (
    input  fetch_req, pc_write, pc_src, branch_offset, jump_index, jr_target, rom_data,
    output rom_addr, rom_rw, pc, instr, instr_valid, fetch_fault, fetch_count
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage of the multicycle CPU.
// It owns the PC, reads the big-endian ROM word at the PC into the IR and
// advances the PC by 4. It applies branch, jump and jr redirects while an
// instruction is held. A misaligned or out-of-range fetch sets a sticky
// fault that only reset clears.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : instruction_fetch_unit_if.slave (control, ROM and status signals)
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ROM_BYTES = 256
) (
  input  logic                          clk,
  input  logic                          reset,
  instruction_fetch_unit_if.slave       bus
);

  typedef enum logic [1:0] {IDLE, FETCH, HELD, FAULT} state_t;

  localparam logic [31:0] LAST_PC = 32'(ROM_BYTES - 4);

  state_t      state_q;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q;
  logic [31:0] count_q;
  logic        valid_q;
  logic        fault_q;
  logic        fetch_ok;

  // Redirect target. The FSM applies it only in HELD, where pc already
  // holds PC+4 of the held instruction.
  always_comb begin
    pc_d = pc_q;
    if (bus.pc_write) begin
      unique case (bus.pc_src)
        2'b01:   pc_d = pc_q + (bus.branch_offset << 2);
        2'b10:   pc_d = {pc_q[31:28], bus.jump_index, 2'b00};
        2'b11:   pc_d = bus.jr_target;
        default: pc_d = pc_q;
      endcase
    end
  end

  assign fetch_ok = (pc_q[1:0] == 2'b00) && (pc_q <= LAST_PC);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (bus.fetch_req) state_q <= FETCH;
        FETCH: begin
          if (!fetch_ok) begin
            fault_q <= 1'b1;
            state_q <= FAULT;
          end else begin
            instr_q <= bus.rom_data;
            pc_q    <= pc_q + 32'd4;
            count_q <= count_q + 32'd1;
            valid_q <= 1'b1;
            state_q <= HELD;
          end
        end
        HELD: begin
          // The redirect lands at the same edge as a new request, so
          // FETCH reads the redirected pc.
          pc_q <= pc_d;
          if (bus.fetch_req) begin
            valid_q <= 1'b0;
            state_q <= FETCH;
          end
        end
        FAULT: state_q <= FAULT;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rom_addr    = pc_q;
  assign bus.rom_rw      = 1'b0;
  assign bus.pc          = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.fetch_fault = fault_q;
  assign bus.fetch_count = count_q;

endmodule
